// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and the vertical phase type.
package vga_timing_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } v_state_t;
endpackage

// File: rtl/vertical_counter.sv
// vertical_counter: line counter, vertical phase FSM and frame_start pulse.
module vertical_counter
  import vga_timing_pkg::*;
#(
  parameter int V_VISIBLE_P = V_VISIBLE,
  parameter int V_FRONT_P = V_FRONT,
  parameter int V_SYNC_P = V_SYNC,
  parameter int V_BACK_P = V_BACK
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic        enable_V_Counter,
  output logic [15:0] v_Count_Value,
  output logic [15:0] v_Count_Next,
  output v_state_t    v_state,
  output logic        frame_start
);
  localparam logic [15:0] V_LAST = 16'(V_VISIBLE_P + V_FRONT_P + V_SYNC_P + V_BACK_P - 1);
  localparam logic [15:0] V_FS = 16'(V_VISIBLE_P);
  localparam logic [15:0] V_SS = 16'(V_VISIBLE_P + V_FRONT_P);
  localparam logic [15:0] V_SE = 16'(V_VISIBLE_P + V_FRONT_P + V_SYNC_P - 1);
  logic [15:0] v_q, v_d;
  v_state_t st_q, st_d;
  logic fs_q, fs_d, wrap;
  // Phase is decoded from the next count, so state and count can never disagree.
  always_comb begin
    wrap = enable_V_Counter && (v_q >= V_LAST);
    v_d = !enable_V_Counter ? v_q : wrap ? 16'd0 : v_q + 16'd1;
    st_d = (v_d < V_FS) ? ST_ACTIVE : (v_d < V_SS) ? ST_FRONT : (v_d <= V_SE) ? ST_SYNC : ST_BACK;
    fs_d = wrap;
  end
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      st_q <= ST_ACTIVE;
      fs_q <= 1'b0;
    end else begin
      v_q <= v_d;
      st_q <= st_d;
      fs_q <= fs_d;
    end
  end
  assign v_Count_Value = v_q;
  assign v_Count_Next = v_d;
  assign v_state = st_q;
  assign frame_start = fs_q;
endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: registered sync/blanking decode from h position and vertical counter.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE_P = H_VISIBLE,
  parameter int H_FRONT_P = H_FRONT,
  parameter int H_SYNC_P = H_SYNC,
  parameter int H_BACK_P = H_BACK,
  parameter int V_VISIBLE_P = V_VISIBLE,
  parameter int V_FRONT_P = V_FRONT,
  parameter int V_SYNC_P = V_SYNC,
  parameter int V_BACK_P = V_BACK
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic        enable_V_Counter,
  input  logic [15:0] h_Count_Value,
  output logic [15:0] v_Count_Value,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [1:0]  v_state
);
  localparam logic [15:0] H_VIS = 16'(H_VISIBLE_P);
  localparam logic [15:0] H_SS = 16'(H_VISIBLE_P + H_FRONT_P);
  localparam logic [15:0] H_SE = 16'(H_VISIBLE_P + H_FRONT_P + H_SYNC_P - 1);
  localparam logic [15:0] V_VIS = 16'(V_VISIBLE_P);
  localparam logic [15:0] V_SS = 16'(V_VISIBLE_P + V_FRONT_P);
  localparam logic [15:0] V_SE = 16'(V_VISIBLE_P + V_FRONT_P + V_SYNC_P - 1);
  logic [15:0] v_next;
  v_state_t st;
  logic hs_q, hs_d, vs_q, vs_d, vo_q, vo_d;
  logic [9:0] px_q, px_d, py_q, py_d;
  vertical_counter #(
    .V_VISIBLE_P(V_VISIBLE_P),
    .V_FRONT_P(V_FRONT_P),
    .V_SYNC_P(V_SYNC_P),
    .V_BACK_P(V_BACK_P)
  ) u_vcnt (
    .clk_25MHz(clk_25MHz),
    .rst(rst),
    .enable_V_Counter(enable_V_Counter),
    .v_Count_Value(v_Count_Value),
    .v_Count_Next(v_next),
    .v_state(st),
    .frame_start(frame_start)
  );
  // Decode uses the count the line register is about to take, keeping h and v aligned.
  always_comb begin
    hs_d = !((h_Count_Value >= H_SS) && (h_Count_Value <= H_SE));
    vs_d = !((v_next >= V_SS) && (v_next <= V_SE));
    vo_d = (h_Count_Value < H_VIS) && (v_next < V_VIS);
    px_d = vo_d ? h_Count_Value[9:0] : 10'd0;
    py_d = vo_d ? v_next[9:0] : 10'd0;
  end
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      vo_q <= 1'b0;
      px_q <= '0;
      py_q <= '0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      vo_q <= vo_d;
      px_q <= px_d;
      py_q <= py_d;
    end
  end
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign video_on = vo_q;
  assign pixel_x = px_q;
  assign pixel_y = py_q;
  assign v_state = st;
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: directed scoreboard bench for vga_sync_generator.
module tb_vga_sync_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [15:0] h = '0;
  logic [15:0] v_out;
  logic hs, vs, vo, fs;
  logic [9:0] px, py;
  logic [1:0] st;
  int tests = 0;
  int fails = 0;
  logic [15:0] m_v = '0;
  typedef struct {
    logic hs, vs, vo, fs;
    logic [9:0] px, py;
    logic [15:0] v;
    logic [1:0] st;
  } exp_t;
  exp_t sb[$];

  vga_sync_generator dut (
    .clk_25MHz(clk),
    .rst(rst),
    .enable_V_Counter(en),
    .h_Count_Value(h),
    .v_Count_Value(v_out),
    .hsync(hs),
    .vsync(vs),
    .video_on(vo),
    .pixel_x(px),
    .pixel_y(py),
    .frame_start(fs),
    .v_state(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (model v=%0d)", tag, obs, exp, m_v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " v"}, v_out, 16'd0);
    chk({tag, " state"}, 16'(st), 16'd0);
    chk({tag, " hsync"}, 16'(hs), 16'd1);
    chk({tag, " vsync"}, 16'(vs), 16'd1);
    chk({tag, " video_on"}, 16'(vo), 16'd0);
    chk({tag, " pixel_x"}, 16'(px), 16'd0);
    chk({tag, " pixel_y"}, 16'(py), 16'd0);
    chk({tag, " frame_start"}, 16'(fs), 16'd0);
  endtask

  task automatic step(input logic [15:0] hv, input logic e);
    exp_t x;
    logic [15:0] hh;
    h = hv;
    en = e;
    hh = hv;
    x.fs = e && (m_v == 16'd524);
    if (e) m_v = (m_v == 16'd524) ? 16'd0 : m_v + 16'd1;
    x.v = m_v;
    x.hs = !(hh >= 16'd656 && hh <= 16'd751);
    x.vs = !(m_v >= 16'd490 && m_v <= 16'd491);
    x.vo = (hh < 16'd640) && (m_v < 16'd480);
    x.px = x.vo ? hh[9:0] : 10'd0;
    x.py = x.vo ? m_v[9:0] : 10'd0;
    x.st = (m_v < 16'd480) ? 2'd0 : (m_v < 16'd490) ? 2'd1 : (m_v < 16'd492) ? 2'd2 : 2'd3;
    sb.push_back(x);
    @(posedge clk);
    #1;
    en = 1'b0;
    x = sb.pop_front();
    chk("v_count", v_out, x.v);
    chk("hsync", 16'(hs), 16'(x.hs));
    chk("vsync", 16'(vs), 16'(x.vs));
    chk("video_on", 16'(vo), 16'(x.vo));
    chk("pixel_x", 16'(px), 16'(x.px));
    chk("pixel_y", 16'(py), 16'(x.py));
    chk("frame_start", 16'(fs), 16'(x.fs));
    chk("v_state", 16'(st), 16'(x.st));
  endtask

  initial begin
    int nfs;
    int lines[2];
    int first_fs, second_fs;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset_hold");
    rst = 1'b0;
    step(16'd0, 1'b0);
    step(16'd655, 1'b0);
    step(16'd656, 1'b0);
    step(16'd751, 1'b0);
    step(16'd752, 1'b0);
    step(16'd639, 1'b0);
    step(16'd640, 1'b0);
    step(16'd900, 1'b0);
    step(16'hFFFF, 1'b0);
    chk("h_overflow hsync", 16'(hs), 16'd1);
    for (int i = 0; i < 489; i++) step(16'd0, 1'b1);
    chk("at_489 vsync", 16'(vs), 16'd1);
    step(16'd0, 1'b1);
    chk("at_490 vsync", 16'(vs), 16'd0);
    step(16'd0, 1'b1);
    step(16'd0, 1'b1);
    chk("at_492 vsync", 16'(vs), 16'd1);
    for (int i = 0; i < 32; i++) step(16'd0, 1'b1);
    chk("at_524 v", v_out, 16'd524);
    step(16'd0, 1'b1);
    chk("wrap frame_start", 16'(fs), 16'd1);
    step(16'd0, 1'b0);
    chk("after_wrap frame_start", 16'(fs), 16'd0);
    nfs = 0;
    lines[0] = 0;
    lines[1] = 0;
    first_fs = -1;
    second_fs = -1;
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 525; l++) begin
        step(16'd0, 1'b1);
        if (fs) begin
          if (nfs == 0) first_fs = f * 525 + l;
          else second_fs = f * 525 + l;
          nfs++;
        end
        step(16'd639, 1'b0);
        if (vo) lines[f]++;
        step(16'd700, 1'b0);
      end
    end
    chk("freerun frame_starts", 16'(nfs), 16'd2);
    chk("freerun frame_period", 16'(second_fs - first_fs), 16'd525);
    chk("freerun lines f0", 16'(lines[0]), 16'd480);
    chk("freerun lines f1", 16'(lines[1]), 16'd480);
    for (int i = 0; i < 300; i++) step(16'd400, 1'b1);
    chk("pre_reset v", v_out, 16'd300);
    h = 16'd400;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("async_reset");
    @(posedge clk);
    #1;
    chk_reset("reset_held");
    rst = 1'b0;
    m_v = '0;
    step(16'd400, 1'b0);
    step(16'd0, 1'b1);
    chk("post_reset v", v_out, 16'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
